// File: rtl/schedm2_pkg.sv
// schedm2 shared types: scheduler state codes.
// The state codes double as the clk_stat encoding.
package schedm2_pkg;

  typedef enum logic [2:0] {
    ST_F = 3'd0,
    ST_E = 3'd1,
    ST_M = 3'd2,
    ST_W = 3'd3,
    ST_H = 3'd4
  } state_t;

endpackage

// File: rtl/schedm2_wcnt.sv
// schedm2 wait-state counter: loadable down-counter.
// Load wins over decrement; decrement saturates at zero.
module schedm2_wcnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load)
      cnt <= din;
    else if (dec && !zero)
      cnt <= cnt - WIDTH'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/schedm2.sv
// schedm2: F/E/M/W phase scheduler with wait states,
// bus-ready handshake, memory-phase skip, debug halt/step.
module schedm2
  import schedm2_pkg::*;
#(
  parameter int WS_WIDTH  = 4,
  parameter int CNT_WIDTH = 32,
  parameter int USE_READY = 1,
  parameter int SKIP_MEM  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mbus_ready,
  input  logic                 need_mem,
  input  logic [WS_WIDTH-1:0]  ws_fetch,
  input  logic [WS_WIDTH-1:0]  ws_mem,
  input  logic                 halt,
  input  logic                 step,
  output logic                 phf,
  output logic                 phe,
  output logic                 phm,
  output logic                 phw,
  output logic                 ph_last,
  output logic                 stall,
  output logic                 halted,
  output logic [2:0]           clk_stat,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  state_t              state;
  state_t              nxt;
  logic                mem_flag;
  logic                zero;
  logic                ready_ok;
  logic                done;
  logic                wload;
  logic                wdec;
  logic [WS_WIDTH-1:0] wdin;

  assign ready_ok = (USE_READY == 0) || mbus_ready;

  // A forced M visit (no memory access) ignores the bus.
  always_comb begin
    done = 1'b0;
    unique case (state)
      ST_F:    done = zero && ready_ok;
      ST_E:    done = 1'b1;
      ST_M:    done = zero && (ready_ok || !mem_flag);
      ST_W:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign ph_last = done;
  assign stall   = ((state == ST_F) || (state == ST_M))
                   && !done;

  always_comb begin
    nxt = state;
    unique case (state)
      ST_F: if (done) nxt = ST_E;
      ST_E: begin
        if (need_mem || (SKIP_MEM == 0))
          nxt = ST_M;
        else
          nxt = ST_W;
      end
      ST_M: if (done) nxt = ST_W;
      ST_W: nxt = halt ? ST_H : ST_F;
      ST_H: if (!halt || step) nxt = ST_F;
      default: nxt = ST_F;
    endcase
  end

  always_comb begin
    wload = reset || (state == ST_E)
            || (((state == ST_W) || (state == ST_H))
                && (nxt == ST_F));
    wdin  = ws_fetch;
    if (!reset && (state == ST_E))
      wdin = need_mem ? ws_mem : '0;
    wdec  = !reset && !zero
            && ((state == ST_F) || (state == ST_M));
  end

  schedm2_wcnt #(
    .WIDTH (WS_WIDTH)
  ) u_wcnt (
    .clk  (clk),
    .load (wload),
    .din  (wdin),
    .dec  (wdec),
    .zero (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_F;
      mem_flag  <= 1'b0;
      phf       <= 1'b1;
      phe       <= 1'b0;
      phm       <= 1'b0;
      phw       <= 1'b0;
      halted    <= 1'b0;
      clk_stat  <= ST_F;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state    <= nxt;
      phf      <= (nxt == ST_F);
      phe      <= (nxt == ST_E);
      phm      <= (nxt == ST_M);
      phw      <= (nxt == ST_W);
      halted   <= (nxt == ST_H);
      clk_stat <= nxt;
      if (state == ST_E)
        mem_flag <= need_mem;
      if (state != ST_H)
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (state == ST_W)
        instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
